// File: rtl/fan_pkg.sv
// Shared constants and helpers for the fan off-timer: one-hot OFF code,
// BCD digit limits, preset durations and the parameter legality check.
package fan_pkg;

  localparam logic [31:0] OFF_ONEHOT = 32'h0000_0001;
  localparam logic [3:0]  BCD_MAX_9  = 4'd9;
  localparam logic [3:0]  BCD_MAX_5  = 4'd5;

  // Preset k lasts (2k-1)*step_min minutes, returned as two BCD digits.
  function automatic logic [7:0] preset_minutes(input int k, input int step_min);
    int m;
    m = (2 * k - 1) * step_min;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic bit params_ok(input int num_presets, input int step_min,
                                   input int tick_div, input int warn_sec);
    return (num_presets >= 1) && (step_min >= 1) &&
           ((2 * num_presets - 1) * step_min <= 99) &&
           (tick_div >= 2) && (warn_sec >= 1) && (warn_sec <= 59);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with synchronous load; borrow flags a
// decrement through zero so the next-higher digit can follow.
module bcd_down_digit
  import fan_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  logic [3:0] digit_d, digit_q;

  // Load wins over decrement; decrementing zero wraps to MAX and borrows.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      if (digit_q == 4'd0) begin
        digit_d = MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec & (digit_q == 4'd0);

endmodule

// File: rtl/fan_off_timer.sv
// Fan off-timer: button cycles OFF/presets, BCD mm:ss countdown from a 1 s tick.
// Optional warning output enabled by defining FAN_TIMER_WARN_EN.
module fan_off_timer
  import fan_pkg::*;
#(
  parameter int NUM_PRESETS = 3,
  parameter int STEP_MIN    = 1,
  parameter int TICK_DIV    = 100_000_000,
  parameter int WARN_SEC    = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   btn_pulse,
  input  logic                   run_e,
  input  logic                   hold,
  output logic [NUM_PRESETS:0]   state,
  output logic [15:0]            cur_time,
  output logic                   active,
  output logic                   timeout_pulse,
  output logic                   warn
);

  localparam int SW = NUM_PRESETS + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [SW-1:0] OFF_STATE = OFF_ONEHOT[SW-1:0];

  if (!params_ok(NUM_PRESETS, STEP_MIN, TICK_DIV, WARN_SEC)) begin : g_bad_params
    $error("fan_off_timer: illegal parameter set");
  end

  logic [SW-1:0] state_d, state_q, rot_s;
  logic [PW-1:0] presc_d, presc_q;
  logic          pulse_d, pulse_q;
  logic          active_s, tick_s, expire_s;
  logic          load_s, dec_s;
  logic [15:0]   load_time_s, preset_time_s;
  logic [3:0]    sec1_s, sec10_s, min1_s, min10_s;
  logic          sec1_borrow_s, sec10_borrow_s, min1_borrow_s, min10_borrow_unused_s;

  assign active_s = (state_q != OFF_STATE);
  assign tick_s   = active_s && !hold && (presc_q == PW'(TICK_DIV - 1));
  assign expire_s = tick_s && ({min10_s, min1_s, sec10_s, sec1_s} == 16'h0001);
  assign rot_s    = {state_q[SW-2:0], state_q[SW-1]};

  // Duration loaded when the button moves into the next preset.
  always_comb begin
    preset_time_s = 16'h0000;
    for (int k = 1; k <= NUM_PRESETS; k++) begin
      preset_time_s = rot_s[k] ? {preset_minutes(k, STEP_MIN), 8'h00} : preset_time_s;
    end
  end

  // Control in priority order: disable, expiry, button, hold, counting.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    pulse_d     = 1'b0;
    load_s      = 1'b0;
    load_time_s = 16'h0000;
    dec_s       = 1'b0;
    if (!run_e) begin
      state_d = OFF_STATE;
      presc_d = '0;
      load_s  = 1'b1;
    end else if (expire_s) begin
      state_d = OFF_STATE;
      presc_d = '0;
      load_s  = 1'b1;
      pulse_d = 1'b1;
    end else if (btn_pulse) begin
      state_d     = rot_s;
      presc_d     = '0;
      load_s      = 1'b1;
      load_time_s = preset_time_s;
    end else if (hold) begin
      presc_d = presc_q;
    end else if (active_s) begin
      if (tick_s) begin
        presc_d = '0;
        dec_s   = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  // State, prescaler and timeout pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF_STATE;
      presc_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pulse_q <= pulse_d;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX_9)) u_sec1 (
    .clk(clk), .reset_n(reset_n), .load(load_s), .load_val(load_time_s[3:0]),
    .dec(dec_s), .digit(sec1_s), .borrow(sec1_borrow_s)
  );
  bcd_down_digit #(.MAX(BCD_MAX_5)) u_sec10 (
    .clk(clk), .reset_n(reset_n), .load(load_s), .load_val(load_time_s[7:4]),
    .dec(sec1_borrow_s), .digit(sec10_s), .borrow(sec10_borrow_s)
  );
  bcd_down_digit #(.MAX(BCD_MAX_9)) u_min1 (
    .clk(clk), .reset_n(reset_n), .load(load_s), .load_val(load_time_s[11:8]),
    .dec(sec10_borrow_s), .digit(min1_s), .borrow(min1_borrow_s)
  );
  bcd_down_digit #(.MAX(BCD_MAX_9)) u_min10 (
    .clk(clk), .reset_n(reset_n), .load(load_s), .load_val(load_time_s[15:12]),
    .dec(min1_borrow_s), .digit(min10_s), .borrow(min10_borrow_unused_s)
  );

`ifdef FAN_TIMER_WARN_EN
  logic [7:0] sec_bin_s;
  logic       warn_d, warn_q;

  // Warn tracks the value cur_time takes on this edge; any load is >= 1 min.
  always_comb begin
    sec_bin_s = 8'(sec10_s) * 8'd10 + 8'(sec1_s);
    warn_d    = warn_q;
    if (load_s) begin
      warn_d = 1'b0;
    end else if (dec_s) begin
      warn_d = (min10_s == 4'd0) && (min1_s == 4'd0) && (sec_bin_s <= 8'(WARN_SEC + 1));
    end else begin
      warn_d = warn_q;
    end
  end

  // Warning register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign state         = state_q;
  assign cur_time      = {min10_s, min1_s, sec10_s, sec1_s};
  assign active        = active_s;
  assign timeout_pulse = pulse_q;

endmodule
